fifo_rd_stream: RTL and testbench

- Read-side adapter that drains a NORMAL-mode synchronous FIFO and presents its contents as a valid/ready stream.
- The attached FIFO has 1-cycle read latency: dout updates on the clock after an accepted rd_en.
- This block issues rd_en speculatively and holds returning words in a 2-entry output buffer, so sustained throughput is 1 word/clk under backpressure.
- Optionally marks packet boundaries with m_last every PKT_LEN words.

---
 rtl/fifo_rd_stream_pkg.sv | 16 +
 rtl/stream_buf2.sv | 63 ++++++
 rtl/fifo_rd_stream.sv | 68 ++++++
 tb/tb_fifo_rd_stream.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and helpers for the FIFO read-side stream adapter.
package fifo_rd_stream_pkg;

  localparam int BUF_DEPTH = 2;

  // Occupancy of the 2-entry output buffer: 0, 1 or 2.
  typedef logic [1:0] occ_t;

  function automatic int log2_ceil(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/stream_buf2.sv
// Two-entry FIFO-ordered skid buffer; entry 0 is the head and drives the output.
module stream_buf2
  import fifo_rd_stream_pkg::*;
#(
  parameter int DSIZE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr,
  input  logic [DSIZE-1:0] i_wdata,
  input  logic             i_rd,
  output occ_t             o_occ,
  output logic [DSIZE-1:0] o_head,
  output logic             o_valid
);

  occ_t             r_occ;
  logic             r_valid;
  logic [DSIZE-1:0] r_ent0;
  logic [DSIZE-1:0] r_ent1;

  logic             w_rd;
  occ_t             w_occ_nxt;
  occ_t             w_wr_slot;

  assign w_rd      = i_rd & r_valid;
  // A pop in the same cycle shifts the tail down, so the write lands one slot lower.
  assign w_wr_slot = r_occ - occ_t'(w_rd);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_occ_nxt = r_occ;
    case ({i_wr, w_rd})
      2'b10:   w_occ_nxt = r_occ + occ_t'(1);
      2'b01:   w_occ_nxt = r_occ - occ_t'(1);
      default: w_occ_nxt = r_occ;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ   <= '0;
      r_valid <= 1'b0;
      // NOTE: the two data entries are reset too, so m_data reads 0 after reset.
      r_ent0  <= '0;
      r_ent1  <= '0;
    end else begin
      r_occ   <= w_occ_nxt;
      r_valid <= (w_occ_nxt != '0);
      if (w_rd) r_ent0 <= r_ent1;
      if (i_wr) begin
        if (w_wr_slot == '0) r_ent0 <= i_wdata;
        else                 r_ent1 <= i_wdata;
      end
    end
  end

  assign o_occ   = r_occ;
  assign o_head  = r_ent0;
  assign o_valid = r_valid;

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a 1-cycle-latency synchronous FIFO into a valid/ready stream,
// reading speculatively into a 2-entry buffer for 1 word/clk throughput.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DSIZE   = 8,
  parameter int PKT_LEN = 0,
  parameter int CW      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [DSIZE-1:0] fifo_dout,
  output logic             fifo_rd_en,
  output logic [DSIZE-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             busy
);

  localparam logic [CW-1:0] LAST_IDX = CW'((PKT_LEN == 0) ? 0 : PKT_LEN - 1);

  occ_t          w_occ;
  logic          w_valid;
  logic          w_pop;
  logic          w_acc;
  logic [2:0]    w_pending;
  logic          r_infl;
  logic [CW-1:0] r_pkt_cnt;

  assign w_pop     = w_valid & m_ready;
  // Words held or in flight once this cycle's pop leaves; a new read may make it at most 2.
  assign w_pending = {1'b0, w_occ} + {2'b00, r_infl} - {2'b00, w_pop};
  assign fifo_rd_en = ~rst & ~fifo_empty & (w_pending <= 3'd1);
  assign w_acc     = fifo_rd_en & ~fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) r_infl <= 1'b0;
    else     r_infl <= w_acc;
  end

  stream_buf2 #(
    .DSIZE (DSIZE)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_wr    (r_infl),
    .i_wdata (fifo_dout),
    .i_rd    (w_pop),
    .o_occ   (w_occ),
    .o_head  (m_data),
    .o_valid (w_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pkt_cnt <= '0;
    end else if (w_pop) begin
      r_pkt_cnt <= (r_pkt_cnt == LAST_IDX) ? '0 : r_pkt_cnt + CW'(1);
    end
  end

  assign m_valid = w_valid;
  assign m_last  = (PKT_LEN != 0) & w_valid & (r_pkt_cnt == LAST_IDX);
  assign busy    = w_valid | r_infl;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: queue-based FIFO environment, word-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_fifo_rd_stream;

  localparam int DSIZE   = 8;
  localparam int PKT_LEN = 4;
  localparam int CW      = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             fifo_empty = 1'b1;
  logic [DSIZE-1:0] fifo_dout = '0;
  logic             fifo_rd_en;
  logic [DSIZE-1:0] m_data;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic             m_last;
  logic             busy;

  logic             fifo_clr = 1'b1;
  logic             wr_en = 1'b0;
  logic [DSIZE-1:0] wr_data = '0;

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_en   = 1'b0;

  fifo_rd_stream #(
    .DSIZE   (DSIZE),
    .PKT_LEN (PKT_LEN),
    .CW      (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Environment: normal-mode FIFO, 1-cycle read latency, registered empty flag.
  logic [DSIZE-1:0] fq[$];
  always @(posedge clk) begin
    if (fifo_clr) begin
      fq.delete();
      fifo_dout  <= '0;
      fifo_empty <= 1'b1;
    end else begin
      if (fifo_rd_en && !fifo_empty) fifo_dout <= fq.pop_front();
      if (wr_en) fq.push_back(wr_data);
      fifo_empty <= (fq.size() == 0);
    end
  end

  // Reference model: word order comes from the writes; timing from the read-issue rule.
  logic [DSIZE-1:0] src_q[$];
  logic [DSIZE-1:0] mod_q[$];
  bit               mod_infl = 1'b0;
  logic [DSIZE-1:0] mod_infl_word = '0;
  int               mod_pops = 0;

  always @(posedge clk) begin
    bit mp, mr;
    if (rst) begin
      mod_q.delete();
      mod_infl = 1'b0;
      mod_pops = 0;
    end else begin
      mp = (mod_q.size() != 0) && m_ready;
      mr = !fifo_empty && ((mod_q.size() + int'(mod_infl) - int'(mp)) <= 1);
      if (mp) begin
        void'(mod_q.pop_front());
        mod_pops++;
      end
      if (mod_infl) mod_q.push_back(mod_infl_word);
      mod_infl = mr;
      if (mr) mod_infl_word = (src_q.size() != 0) ? src_q.pop_front() : 'x;
    end
    if (fifo_clr) src_q.delete();
    else if (wr_en) src_q.push_back(wr_data);
  end

  // Per-cycle comparison, well away from the rising edge.
  int out_cnt = 0;
  bit ev, ep, er, el;
  int pend;
  always @(negedge clk) begin
    #2;
    if (cmp_en) begin
      ev   = (mod_q.size() != 0);
      ep   = ev && m_ready;
      pend = mod_q.size() + int'(mod_infl) - int'(ep);
      er   = !rst && !fifo_empty && (pend <= 1);
      el   = ev && ((mod_pops % PKT_LEN) == PKT_LEN - 1);
      check("m_valid", m_valid, ev);
      if (ev) check("m_data", m_data, mod_q[0]);
      check("m_last", m_last, el);
      check("busy", busy, ev || mod_infl);
      check("fifo_rd_en", fifo_rd_en, er);
      check("occ_plus_infl_le_2", out_cnt <= 2, 1);
      if (rst) out_cnt = 0;
      else out_cnt = out_cnt + int'(fifo_rd_en && !fifo_empty) - int'(m_valid && m_ready);
    end
  end

  task automatic cyc(input logic r, input logic c, input logic rdy, input logic w,
                     input logic [DSIZE-1:0] d);
    @(negedge clk);
    rst = r; fifo_clr = c; m_ready = rdy; wr_en = w; wr_data = d;
    #1;
  endtask

  task automatic do_reset();
    cyc(1, 1, 0, 0, '0);
    cyc(1, 1, 0, 0, '0);
  endtask

  int first_rd, first_v, n_v, last_v, n_rd;
  logic [DSIZE-1:0] got_q[$];
  logic [15:0] last_mask;
  logic [DSIZE-1:0] prev_data;
  bit prev_stall;
  bit pat[6] = '{1, 0, 0, 1, 0, 1};

  initial begin
    // Reset with a preloaded FIFO.
    do_reset();
    cmp_en = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, DSIZE'(8'h11 * (i + 1)));
    cyc(1, 0, 0, 0, '0);
    cyc(1, 0, 0, 0, '0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    first_rd = -1; first_v = -1;
    for (int k = 0; k < 10; k++) begin
      cyc(0, 0, 1, 0, '0);
      if (fifo_rd_en && first_rd < 0) first_rd = k;
      if (m_valid && first_v < 0) begin
        first_v = k;
        check("first_word", m_data, 8'h11);
      end
    end
    check("first_rd_cycle", first_rd, 0);
    check("rd_to_valid_latency", first_v - first_rd, 2);

    // Streaming 0x01..0x10 with constant ready.
    do_reset();
    n_v = 0; first_v = -1; last_v = -1;
    for (int k = 0; k < 26; k++) begin
      if (k < 16) cyc(0, 0, 1, 1, DSIZE'(k + 1));
      else        cyc(0, 0, 1, 0, '0);
      if (m_valid) begin
        check("stream_data", m_data, n_v + 1);
        n_v++;
        if (first_v < 0) first_v = k;
        last_v = k;
      end
    end
    check("stream_count", n_v, 16);
    check("stream_no_bubble", last_v - first_v, 15);

    // Backpressure pattern with randomized extra stalls after the fixed pattern.
    do_reset();
    got_q.delete(); prev_stall = 0; prev_data = '0;
    for (int k = 0; k < 70; k++) begin
      cyc(0, 0, (k < 30) ? logic'(pat[k % 6]) : logic'($urandom_range(0, 1)),
          k < 8, DSIZE'(8'h30 + k));
      if (prev_stall) check("stall_data_stable", m_data, prev_data);
      if (m_valid && m_ready) got_q.push_back(m_data);
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
    check("bp_count", got_q.size(), 8);
    for (int i = 0; i < got_q.size() && i < 8; i++) check("bp_order", got_q[i], 8'h30 + i);

    // Long stall: only two reads, then full rate on resume.
    do_reset();
    n_rd = 0;
    for (int k = 0; k < 15; k++) begin
      if (k < 5) cyc(0, 0, 0, 1, DSIZE'(8'h50 + k));
      else       cyc(0, 0, 0, 0, '0);
      if (fifo_rd_en && !fifo_empty) n_rd++;
    end
    check("stall_reads", n_rd, 2);
    check("stall_rd_en_low", fifo_rd_en, 0);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 1, 0, '0);
      check("resume_valid", m_valid, 1);
      check("resume_data", m_data, 8'h50 + k);
    end

    // Packets of 4: m_last on words 4 and 8 of 10.
    do_reset();
    n_v = 0; last_mask = '0;
    for (int k = 0; k < 20; k++) begin
      if (k < 10) cyc(0, 0, 1, 1, DSIZE'($urandom));
      else        cyc(0, 0, 1, 0, '0);
      if (m_valid && m_ready) begin
        last_mask[n_v] = m_last;
        n_v++;
      end
    end
    check("pkt_count", n_v, 10);
    check("pkt_last_mask", last_mask, 16'h0088);

    // Reset mid-stream with a word in flight, then refill.
    do_reset();
    for (int k = 0; k < 8; k++) cyc(0, 0, 0, k < 4, DSIZE'(8'h60 + k));
    cyc(0, 0, 1, 0, '0);
    check("pre_rst_busy", busy, 1);
    check("pre_rst_rd_en", fifo_rd_en, 1);
    cyc(1, 1, 0, 0, '0);
    cyc(1, 1, 0, 0, '0);
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_busy", busy, 0);
    got_q.delete(); last_mask = '0;
    for (int k = 0; k < 12; k++) begin
      cyc(0, 0, 1, k < 4, DSIZE'(8'hA0 + k));
      if (m_valid && m_ready) begin
        last_mask[got_q.size()] = m_last;
        got_q.push_back(m_data);
      end
    end
    check("refill_count", got_q.size(), 4);
    if (got_q.size() > 0) check("refill_first", got_q[0], 8'hA0);
    check("refill_last_mask", last_mask, 16'h0008);

    cyc(0, 0, 0, 0, '0);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
